// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: opcode encodings, flag bit positions and default datapath width
// shared by the arbiter, its round-robin grant logic and anything driving the ALU.
// Contents: DEFAULT_WIDTH, alu_op_e (ADD..CMPLT), FLAG_* indices, rr_next().
package alu_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int OP_W          = 4;
  localparam int FLAG_W        = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOT   = 4'b0101,
    OP_SHL   = 4'b0110,
    OP_SHR   = 4'b0111,
    OP_CMPEQ = 4'b1000,
    OP_CMPLT = 4'b1001
  } alu_op_e;

  // Flag vector layout: {overflow, underflow, invalid_op, is_equal, is_less}
  localparam int FLAG_OVERFLOW  = 4;
  localparam int FLAG_UNDERFLOW = 3;
  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_EQUAL     = 1;
  localparam int FLAG_LESS      = 0;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant, first set req bit at or after ptr.
// Ports: req (request vector), ptr (search start index), grant (one-hot, or 0 if no req).
// Latency: purely combinational; no state.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  int          pos;
  logic [PW-1:0] idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    // Walk the requesters starting at ptr, wrapping modulo NREQ.
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = PW'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin shares one external ALU among NREQ requesters; tags follow
// each issue slot so the result is steered back as a one-hot resp_valid strobe.
// Ports: req_* (valid/ready per requester), alu_* (registered issue / ALU return),
//        resp_* (registered response), busy, issue_count (saturating accepted count).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*OP_W-1:0]    req_op,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [OP_W-1:0]         alu_op,
  input  logic [WIDTH-1:0]        alu_result,
  input  logic [FLAG_W-1:0]       alu_flags,
  output logic [NREQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]        resp_result,
  output logic [FLAG_W-1:0]       resp_flags,
  output logic                    busy,
  output logic [15:0]             issue_count
);

  localparam int IW    = $clog2(NREQ);
  localparam int DEPTH = 1 + ALU_LAT;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [15:0]       issue_count_q, issue_count_d;
  logic [WIDTH-1:0]  alu_a_q, alu_b_q, resp_result_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [FLAG_W-1:0] resp_flags_q;
  logic [NREQ-1:0]   resp_valid_q;
  tag_t              tag_q [DEPTH];

  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     gnt_idx;
  logic              xfer;
  logic              busy_w;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Grant is already a subset of req_valid; reset only needs to mask it.
  assign req_ready = rst_n ? grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_idx = IW'(i);
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    issue_count_d = issue_count_q;
    if (xfer) begin
      rr_ptr_d = IW'(rr_next(int'(gnt_idx), NREQ));
      if (issue_count_q != 16'hFFFF) issue_count_d = issue_count_q + 16'd1;
    end
  end

  always_comb begin
    busy_w = 1'b0;
    for (int s = 0; s < DEPTH; s++) busy_w = busy_w | tag_q[s].vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      issue_count_q <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      for (int s = 0; s < DEPTH; s++) tag_q[s] <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      issue_count_q <= issue_count_d;
      // An empty slot drives zero operands and opcode 0000 so the ALU sees a quiet bus.
      if (xfer) begin
        alu_a_q  <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        alu_b_q  <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        alu_op_q <= req_op[int'(gnt_idx)*OP_W +: OP_W];
      end else begin
        alu_a_q  <= '0;
        alu_b_q  <= '0;
        alu_op_q <= '0;
      end
      // Tag shifts in lockstep with the ALU; the last stage lines up with alu_result.
      tag_q[0].vld <= xfer;
      tag_q[0].idx <= gnt_idx;
      for (int s = 1; s < DEPTH; s++) tag_q[s] <= tag_q[s-1];
      if (tag_q[DEPTH-1].vld) begin
        resp_valid_q  <= NREQ'(1) << tag_q[DEPTH-1].idx;
        resp_result_q <= alu_result;
        resp_flags_q  <= alu_flags;
      end else begin
        resp_valid_q  <= '0;
      end
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign busy        = busy_w;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table of per-cycle vectors with hand-computed grants and
// results, plus hand sequences for reset-in-flight and issue_count saturation.
// A registered ALU model (one edge of latency) closes the loop around the DUT.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N*4-1:0] req_op = '0;
  logic [W-1:0]   alu_a, alu_b;
  logic [3:0]     alu_op;
  logic [W-1:0]   alu_result = '0;
  logic [4:0]     alu_flags = '0;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_result;
  logic [4:0]     resp_flags;
  logic           busy;
  logic [15:0]    issue_count;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.WIDTH(W), .NREQ(N), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_flags(resp_flags),
    .busy(busy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // External ALU: returns {flags, result}, flags = {ovf, unf, inv, eq, lt}.
  function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
    logic [16:0] s;
    logic [15:0] r;
    logic ovf, unf, inv;
    r = '0; ovf = 1'b0; unf = 1'b0; inv = 1'b0; s = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; ovf = s[16]; end
      4'd1: begin r = a - b; unf = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << b[3:0];
      4'd7: r = a >> b[3:0];
      4'd8: r = {15'd0, a == b};
      4'd9: r = {15'd0, a < b};
      default: inv = 1'b1;
    endcase
    return {ovf, unf, inv, (a == b), (a < b), r};
  endfunction

  always @(posedge clk) {alu_flags, alu_result} <= alu_model(alu_a, alu_b, alu_op);

  typedef struct packed {
    logic        pre_rst;
    logic [3:0]  vld;
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] op;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_res;
    logic [4:0]  exp_flg;
    logic        chk_cnt;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic pre_rst, input logic [3:0] vld,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [15:0] op, input logic [3:0] rdy,
                              input logic [15:0] res, input logic [4:0] flg);
    vec_t v;
    v.pre_rst = pre_rst; v.vld = vld; v.a = a; v.b = b; v.op = op;
    v.exp_rdy = rdy; v.exp_res = res; v.exp_flg = flg;
    v.chk_cnt = 1'b0; v.exp_cnt = '0;
    return v;
  endfunction

  function automatic vec_t idle(input logic chk_cnt, input logic [15:0] cnt);
    vec_t v;
    v = mk(1'b0, 4'b0000, '0, '0, '0, 4'b0000, '0, '0);
    v.chk_cnt = chk_cnt;
    v.exp_cnt = cnt;
    return v;
  endfunction

  // Expected response pipeline: index 0 = vector just applied, 2 = due now.
  logic [3:0]  e_rv  [3];
  logic [15:0] e_res [3];
  logic [4:0]  e_flg [3];
  logic [15:0] last_res;
  logic [4:0]  last_flg;
  vec_t        prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      e_rv[i] = '0; e_res[i] = '0; e_flg[i] = '0;
    end
    last_res = '0;
    last_flg = '0;
    prev     = idle(1'b0, '0);
  endtask

  // Called at a negedge; checks state due now, applies v, checks grant, waits a cycle.
  task automatic step(input vec_t v);
    logic [15:0] xa, xb;
    logic [3:0]  xo;
    if (v.chk_cnt) chk("issue_count", issue_count, v.exp_cnt);
    chk("resp_valid", resp_valid, e_rv[2]);
    if (e_rv[2] != 0) begin
      last_res = e_res[2];
      last_flg = e_flg[2];
    end
    chk("resp_result", resp_result, last_res);
    chk("resp_flags", resp_flags, last_flg);
    chk("busy", busy, (e_rv[0] != 0) || (e_rv[1] != 0));
    xa = '0; xb = '0; xo = '0;
    for (int i = 0; i < N; i++) begin
      if (prev.exp_rdy[i]) begin
        xa = prev.a[i*16 +: 16];
        xb = prev.b[i*16 +: 16];
        xo = prev.op[i*4 +: 4];
      end
    end
    chk("alu_a", alu_a, xa);
    chk("alu_b", alu_b, xb);
    chk("alu_op", alu_op, xo);
    for (int i = 2; i > 0; i--) begin
      e_rv[i] = e_rv[i-1]; e_res[i] = e_res[i-1]; e_flg[i] = e_flg[i-1];
    end
    e_rv[0] = v.exp_rdy; e_res[0] = v.exp_res; e_flg[0] = v.exp_flg;
    prev = v;
    req_valid = v.vld;
    req_a     = v.a;
    req_b     = v.b;
    req_op    = v.op;
    #1;
    chk("req_ready", req_ready, v.exp_rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = {16'd1, 16'd2, 16'd3, 16'd4};
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_issue_count", issue_count, 16'd0);
    chk("rst_alu_a", alu_a, 16'd0);
    chk("rst_alu_op", alu_op, 4'd0);
    chk("rst_resp_result", resp_result, 16'd0);
    chk("rst_resp_flags", resp_flags, 5'd0);
    rst_n = 1'b1;
    clear_model();
  endtask

  localparam logic [63:0] A2 = {16'd40, 16'd30, 16'd20, 16'd10};
  localparam logic [63:0] B2 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [15:0] O2 = 16'h1010;  // req3 SUB, req2 ADD, req1 SUB, req0 ADD

  vec_t tbl [$];

  initial begin
    clear_model();
    // Single ADD from reset: 100 + 200.
    tbl.push_back(mk(1'b1, 4'b0001, 64'd100, 64'd200, 16'h0000, 4'b0001, 16'd300, 5'b00001));
    for (int i = 0; i < 3; i++) tbl.push_back(idle(1'b0, '0));
    // All four held valid for 8 cycles: strict rotation 0,1,2,3,0,1,2,3.
    tbl.push_back(mk(1'b1, 4'b1111, A2, B2, O2, 4'b0001, 16'd11, 5'd0));
    tbl.push_back(mk(1'b0, 4'b1111, A2, B2, O2, 4'b0010, 16'd18, 5'd0));
    tbl.push_back(mk(1'b0, 4'b1111, A2, B2, O2, 4'b0100, 16'd33, 5'd0));
    tbl.push_back(mk(1'b0, 4'b1111, A2, B2, O2, 4'b1000, 16'd36, 5'd0));
    tbl.push_back(mk(1'b0, 4'b1111, A2, B2, O2, 4'b0001, 16'd11, 5'd0));
    tbl.push_back(mk(1'b0, 4'b1111, A2, B2, O2, 4'b0010, 16'd18, 5'd0));
    tbl.push_back(mk(1'b0, 4'b1111, A2, B2, O2, 4'b0100, 16'd33, 5'd0));
    tbl.push_back(mk(1'b0, 4'b1111, A2, B2, O2, 4'b1000, 16'd36, 5'd0));
    for (int i = 0; i < 3; i++) tbl.push_back(idle(1'b0, '0));
    // ptr=0: grant 1 -> ptr=2; 0011 wraps to 0 -> ptr=1; 0011 -> 1 -> ptr=2;
    // 1100 -> 2, then req3 drops without being granted.
    tbl.push_back(mk(1'b0, 4'b0010, A2, B2, O2, 4'b0010, 16'd18, 5'd0));
    tbl.push_back(mk(1'b0, 4'b0011, A2, B2, O2, 4'b0001, 16'd11, 5'd0));
    tbl.push_back(mk(1'b0, 4'b0011, A2, B2, O2, 4'b0010, 16'd18, 5'd0));
    tbl.push_back(mk(1'b0, 4'b1100, A2, B2, O2, 4'b0100, 16'd33, 5'd0));
    for (int i = 0; i < 2; i++) tbl.push_back(idle(1'b0, '0));
    tbl.push_back(idle(1'b1, 16'd12));
    // Req 3: 50 SUB 80 (underflow, less), then opcode 1111 (invalid, less).
    tbl.push_back(mk(1'b1, 4'b1000, {16'd50, 48'd0}, {16'd80, 48'd0}, 16'h1000,
                     4'b1000, 16'hFFE2, 5'b01001));
    tbl.push_back(mk(1'b0, 4'b1000, {16'd50, 48'd0}, {16'd80, 48'd0}, 16'hF000,
                     4'b1000, 16'h0000, 5'b00101));
    for (int i = 0; i < 2; i++) tbl.push_back(idle(1'b0, '0));
    tbl.push_back(idle(1'b1, 16'd2));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].pre_rst) do_reset();
      step(tbl[i]);
    end

    // Reset pulsed one cycle after a transfer: the in-flight op must vanish.
    step(mk(1'b0, 4'b0001, 64'd7, 64'd8, 16'h0000, 4'b0001, 16'd15, 5'b00001));
    rst_n = 1'b0;
    #1;
    chk("inflight_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 4; i++) step(idle(1'b0, '0));
    chk("inflight_issue_count", issue_count, 16'd0);

    // Saturation: preload FFFE, three transfers must stop at FFFF.
    force dut.issue_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.issue_count_q;
    step(mk(1'b0, 4'b0001, 64'd5, 64'd6, 16'h0000, 4'b0001, 16'd11, 5'b00001));
    step(mk(1'b0, 4'b0001, 64'd9, 64'd9, 16'h0000, 4'b0001, 16'd18, 5'b00010));
    step(mk(1'b0, 4'b0001, 64'hFFFF, 64'd2, 16'h0000, 4'b0001, 16'd1, 5'b10000));
    for (int i = 0; i < 3; i++) step(idle(1'b0, '0));
    chk("sat_issue_count", issue_count, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
